// File: rtl/multicycle_control.sv
// Multicycle processor control unit.
// Moore FSM sequencing FETCH/DECODE/execute/write-back for R-type, LW, SW,
// BEQ, ADDI, SLTI and J; unknown opcodes park the FSM in TRAP until reset.
// Optional feature macro: MULTICYCLE_CONTROL_PERF_EN adds the retired
// instruction counter output instr_count (CNT_W bits, wrapping).
// State encoding on the state output:
//   0 FETCH, 1 DECODE, 2 MEM_ADDR, 3 MEM_RD, 4 MEM_WB, 5 MEM_WR, 6 R_EXEC,
//   7 R_WB, 8 BRANCH, 9 JUMP, 10 I_EXEC, 11 I_WB, 12 TRAP.
// Memory handshake: mem_req/mem_read/mem_write are held stable while the FSM
// waits; an access completes in the cycle where mem_ready is high while the
// request is asserted. mem_ready is ignored in every other state.
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_read,
    output logic             mem_write,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       pc_source,
    output logic [2:0]       alu_op,
    output logic [3:0]       state,
    output logic             illegal
`ifdef MULTICYCLE_CONTROL_PERF_EN
    ,
    output logic [CNT_W-1:0] instr_count
`endif
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_I_EXEC   = 4'd10,
        S_I_WB     = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_J    = 6'b000010;

    // Counter width must be at least one bit; nothing is generated otherwise.
    generate
        if (CNT_W < 1) begin : g_cnt_w_invalid
        end
    endgenerate

    state_t     state_q;
    state_t     state_d;
    logic [5:0] opcode_q;
    logic       mem_req_c;
    logic       ir_write_c;
    logic       pc_write_c;
    logic       reg_write_c;

    // State register and opcode latch; opcode is captured only in DECODE so
    // later instruction-register changes cannot disturb sequencing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_FETCH;
            opcode_q <= 6'b000000;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                opcode_q <= opcode;
            end
        end
    end

    // Next-state and Moore output decode; FETCH write enables follow mem_ready.
    always_comb begin
        state_d       = state_q;
        mem_req_c     = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        iord          = 1'b0;
        ir_write_c    = 1'b0;
        pc_write_c    = 1'b0;
        pc_write_cond = 1'b0;
        reg_write_c   = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_source     = 2'b00;
        alu_op        = 3'b000;
        illegal       = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req_c  = 1'b1;
                mem_read   = 1'b1;
                alu_src_b  = 2'b01;
                alu_op     = 3'b011;
                ir_write_c = mem_ready;
                pc_write_c = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                alu_op    = 3'b011;
                case (opcode)
                    OP_LW, OP_SW:     state_d = S_MEM_ADDR;
                    OP_R:             state_d = S_R_EXEC;
                    OP_BEQ:           state_d = S_BRANCH;
                    OP_J:             state_d = S_JUMP;
                    OP_ADDI, OP_SLTI: state_d = S_I_EXEC;
                    default:          state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 3'b011;
                state_d   = (opcode_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_req_c = 1'b1;
                mem_read  = 1'b1;
                iord      = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write_c = 1'b1;
                mem_to_reg  = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEM_WR: begin
                mem_req_c = 1'b1;
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                state_d   = S_R_WB;
            end
            S_R_WB: begin
                reg_write_c = 1'b1;
                reg_dst     = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 3'b001;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                pc_write_c = 1'b1;
                pc_source  = 2'b10;
                state_d    = S_FETCH;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = (opcode_q == OP_SLTI) ? 3'b010 : 3'b011;
                state_d   = S_I_WB;
            end
            S_I_WB: begin
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Side-effecting enables are forced low for the whole time reset is held.
    assign mem_req   = mem_req_c & rst_n;
    assign ir_write  = ir_write_c & rst_n;
    assign pc_write  = pc_write_c & rst_n;
    assign reg_write = reg_write_c & rst_n;
    assign state     = state_q;

`ifdef MULTICYCLE_CONTROL_PERF_EN
    logic [CNT_W-1:0] count_q;

    // Retired-instruction counter: one per return to FETCH from a completing state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (state_q != S_FETCH && state_q != S_TRAP && state_d == S_FETCH) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign instr_count = count_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control.
// Directed instruction sequences are expanded, per instruction class, into
// the list of states the control unit must visit; each cycle's expected
// control word is queued and one compare process checks it on the falling edge.
module tb_multicycle_control;

    localparam int CNT_W = 4;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    localparam logic [3:0] K_FETCH    = 4'd0;
    localparam logic [3:0] K_DECODE   = 4'd1;
    localparam logic [3:0] K_MEM_ADDR = 4'd2;
    localparam logic [3:0] K_MEM_RD   = 4'd3;
    localparam logic [3:0] K_MEM_WB   = 4'd4;
    localparam logic [3:0] K_MEM_WR   = 4'd5;
    localparam logic [3:0] K_R_EXEC   = 4'd6;
    localparam logic [3:0] K_R_WB     = 4'd7;
    localparam logic [3:0] K_BRANCH   = 4'd8;
    localparam logic [3:0] K_JUMP     = 4'd9;
    localparam logic [3:0] K_I_EXEC   = 4'd10;
    localparam logic [3:0] K_I_WB     = 4'd11;
    localparam logic [3:0] K_TRAP     = 4'd12;

    localparam int W = 23;

    logic             clk;
    logic             rst_n;
    logic [5:0]       opcode;
    logic             mem_ready;
    logic             mem_req, mem_read, mem_write, iord;
    logic             ir_write, pc_write, pc_write_cond, reg_write;
    logic             reg_dst, mem_to_reg, alu_src_a;
    logic [1:0]       alu_src_b, pc_source;
    logic [2:0]       alu_op;
    logic [3:0]       state;
    logic             illegal;
`ifdef MULTICYCLE_CONTROL_PERF_EN
    logic [CNT_W-1:0] instr_count;
`endif

    multicycle_control #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .iord          (iord),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .pc_source     (pc_source),
        .alu_op        (alu_op),
        .state         (state),
        .illegal       (illegal)
`ifdef MULTICYCLE_CONTROL_PERF_EN
        ,
        .instr_count   (instr_count)
`endif
    );

    // Clock and scoreboard state
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0]     exp_q[$];
    logic [W-1:0]     mask_q[$];
    logic [CNT_W-1:0] cnt_q[$];
    logic             cchk_q[$];

    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    int          retired = 0;
    logic [5:0]  latched_op = 6'b0;

    function automatic logic [5:0] rnd_op();
        return 6'($urandom_range(0, 63));
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected control word for a state, from the per-state output table.
    function automatic logic [W-1:0] exp_word(input logic [3:0] k, input logic mr);
        logic       ill, mrq, mrd, mwr, io, irw, pcw, pwc, rw, rd, m2r, a;
        logic [1:0] b, ps;
        logic [2:0] op;
        {ill, mrq, mrd, mwr, io, irw, pcw, pwc, rw, rd, m2r, a} = '0;
        b = 2'b00; ps = 2'b00; op = 3'b000;
        case (k)
            K_FETCH:    begin mrq = 1; mrd = 1; b = 2'b01; op = 3'b011; irw = mr; pcw = mr; end
            K_DECODE:   begin b = 2'b11; op = 3'b011; end
            K_MEM_ADDR: begin a = 1; b = 2'b10; op = 3'b011; end
            K_MEM_RD:   begin mrq = 1; mrd = 1; io = 1; end
            K_MEM_WB:   begin rw = 1; m2r = 1; end
            K_MEM_WR:   begin mrq = 1; mwr = 1; io = 1; end
            K_R_EXEC:   begin a = 1; end
            K_R_WB:     begin rw = 1; rd = 1; end
            K_BRANCH:   begin a = 1; op = 3'b001; pwc = 1; ps = 2'b01; end
            K_JUMP:     begin pcw = 1; ps = 2'b10; end
            K_I_EXEC:   begin a = 1; b = 2'b10; op = (latched_op == OP_SLTI) ? 3'b010 : 3'b011; end
            K_I_WB:     begin rw = 1; end
            K_TRAP:     begin ill = 1; end
            default:    begin end
        endcase
        return {k, ill, mrq, mrd, mwr, io, irw, pcw, pwc, rw, rd, m2r, a, b, ps, op};
    endfunction

    function automatic logic [W-1:0] dut_word();
        return {state, illegal, mem_req, mem_read, mem_write, iord, ir_write, pc_write,
                pc_write_cond, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
                pc_source, alu_op};
    endfunction

    // Compare process: one queued expectation per cycle, checked mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0]     e, m, g;
            logic [CNT_W-1:0] ec;
            logic             cc;
            e  = exp_q.pop_front();
            m  = mask_q.pop_front();
            ec = cnt_q.pop_front();
            cc = cchk_q.pop_front();
            g  = dut_word();
            tests++;
            if ((g & m) !== (e & m)) begin
                fails++;
                $display("FAIL ctrl_word t=%0t got=%h exp=%h mask=%h", $time, g, e, m);
            end
`ifdef MULTICYCLE_CONTROL_PERF_EN
            if (cc) begin
                tests++;
                if (instr_count !== ec) begin
                    fails++;
                    $display("FAIL instr_count t=%0t got=%0d exp=%0d", $time, instr_count, ec);
                end
            end
`endif
        end
    end

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Driver: one clock of stimulus plus its expected outputs.
    task automatic step(input logic [3:0] k, input logic mr, input logic [5:0] op_in);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        mem_ready = mr;
        opcode    = op_in;
        cyc++;
        exp_q.push_back(exp_word(k, mr));
        mask_q.push_back('1);
        cnt_q.push_back(CNT_W'(retired));
        cchk_q.push_back(1'b1);
    endtask

    // Hold reset for n edges; the first cycle only checks the gated enables.
    task automatic do_reset(input int n);
        logic [W-1:0] w;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rst_n     = 1'b0;
            mem_ready = rnd_bit();
            opcode    = rnd_op();
            if (i == 0) begin
                exp_q.push_back('0);
                mask_q.push_back(W'((1 << 17) | (1 << 13) | (1 << 12) | (1 << 10)));
                cnt_q.push_back('0);
                cchk_q.push_back(1'b0);
            end else begin
                w = exp_word(K_FETCH, 1'b0);
                w[17] = 1'b0;
                exp_q.push_back(w);
                mask_q.push_back('1);
                cnt_q.push_back('0);
                cchk_q.push_back(1'b1);
            end
        end
        retired    = 0;
        latched_op = 6'b0;
    endtask

    // One instruction: fw fetch wait states, ww data-memory wait states.
    task automatic run_instr(input logic [5:0] op, input int fw, input int ww, output int n);
        int start;
        start = cyc;
        for (int i = 0; i < fw; i++) step(K_FETCH, 1'b0, rnd_op());
        step(K_FETCH, 1'b1, rnd_op());
        latched_op = op;
        step(K_DECODE, rnd_bit(), op);
        case (op)
            OP_LW: begin
                step(K_MEM_ADDR, rnd_bit(), rnd_op());
                for (int i = 0; i < ww; i++) step(K_MEM_RD, 1'b0, rnd_op());
                step(K_MEM_RD, 1'b1, rnd_op());
                step(K_MEM_WB, rnd_bit(), rnd_op());
            end
            OP_SW: begin
                step(K_MEM_ADDR, rnd_bit(), rnd_op());
                for (int i = 0; i < ww; i++) step(K_MEM_WR, 1'b0, rnd_op());
                step(K_MEM_WR, 1'b1, rnd_op());
            end
            OP_R: begin
                step(K_R_EXEC, rnd_bit(), rnd_op());
                step(K_R_WB, rnd_bit(), rnd_op());
            end
            OP_ADDI, OP_SLTI: begin
                step(K_I_EXEC, rnd_bit(), rnd_op());
                step(K_I_WB, rnd_bit(), rnd_op());
            end
            OP_BEQ: step(K_BRANCH, rnd_bit(), rnd_op());
            OP_J:   step(K_JUMP, rnd_bit(), rnd_op());
            default: begin
                for (int i = 0; i < 10; i++) step(K_TRAP, rnd_bit(), rnd_op());
            end
        endcase
        n = cyc - start;
        if (op inside {OP_LW, OP_SW, OP_R, OP_ADDI, OP_SLTI, OP_BEQ, OP_J}) retired++;
    endtask

    logic [5:0] ops_tbl[7];
    int         lat_tbl[7];

    // Main directed sequence
    initial begin
        int n;
        rst_n = 1'b0; opcode = 6'b0; mem_ready = 1'b0;
        ops_tbl = '{OP_LW, OP_SW, OP_R, OP_ADDI, OP_SLTI, OP_BEQ, OP_J};
        lat_tbl = '{5, 4, 4, 4, 4, 3, 3};

        do_reset(2);

        // First FETCH right after reset release, then LW with no wait states
        step(K_FETCH, 1'b1, rnd_op());
        #2;
        lit("first_fetch_req", {31'b0, mem_req}, 1);
        lit("first_fetch_state", {28'b0, state}, 0);
        latched_op = OP_LW;
        step(K_DECODE, rnd_bit(), OP_LW);
        step(K_MEM_ADDR, rnd_bit(), rnd_op());
        step(K_MEM_RD, 1'b1, rnd_op());
        step(K_MEM_WB, rnd_bit(), rnd_op());
        #2;
        lit("lw_c5_reg_write", {31'b0, reg_write}, 1);
        lit("lw_c5_mem_to_reg", {31'b0, mem_to_reg}, 1);
        retired++;

        // Latency of every class without wait states
        for (int i = 0; i < 7; i++) begin
            run_instr(ops_tbl[i], 0, 0, n);
            lit($sformatf("latency_op%06b", ops_tbl[i]), n, lat_tbl[i]);
        end

        // SW with three wait states; BEQ control fields
        run_instr(OP_SW, 0, 3, n);
        lit("sw_wait_cycles", n, 7);
        run_instr(OP_BEQ, 0, 0, n);
        #2;
        lit("beq_alu_op", {29'b0, alu_op}, 1);
        lit("beq_pc_write_cond", {31'b0, pc_write_cond}, 1);
        lit("beq_pc_source", {30'b0, pc_source}, 1);

        // SLTI then ADDI, then LW with fetch and memory wait states
        run_instr(OP_SLTI, 0, 0, n);
        run_instr(OP_ADDI, 0, 0, n);
        run_instr(OP_LW, 2, 2, n);
        lit("lw_wait_cycles", n, 9);

`ifdef MULTICYCLE_CONTROL_PERF_EN
        // Counter wrap: 17 R-type instructions on a 4-bit counter
        do_reset(1);
        for (int i = 0; i < 17; i++) run_instr(OP_R, 0, 0, n);
        step(K_FETCH, 1'b0, rnd_op());
        #2;
        lit("count_wrap_17", {28'b0, instr_count}, 1);
`endif

        // Reset in the middle of a load's memory read
        step(K_FETCH, 1'b1, rnd_op());
        latched_op = OP_LW;
        step(K_DECODE, rnd_bit(), OP_LW);
        step(K_MEM_ADDR, rnd_bit(), rnd_op());
        step(K_MEM_RD, 1'b0, rnd_op());
        step(K_MEM_RD, 1'b0, rnd_op());
        do_reset(1);
        step(K_FETCH, 1'b0, rnd_op());
        #2;
        lit("mid_rd_reset_state", {28'b0, state}, 0);
`ifdef MULTICYCLE_CONTROL_PERF_EN
        lit("mid_rd_reset_count", {28'b0, instr_count}, 0);
`endif

        // Illegal opcode traps and holds until one reset edge
        run_instr(OP_BAD, 0, 0, n);
        #2;
        lit("trap_illegal", {31'b0, illegal}, 1);
        do_reset(1);
        step(K_FETCH, 1'b1, rnd_op());
        #2;
        lit("after_trap_illegal", {31'b0, illegal}, 0);
        lit("after_trap_state", {28'b0, state}, 0);
        latched_op = OP_J;
        step(K_DECODE, rnd_bit(), OP_J);
        step(K_JUMP, rnd_bit(), rnd_op());
        retired++;
        run_instr(OP_R, 1, 0, n);

        @(posedge clk);
        @(negedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL queue_drain left=%0d exp=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
